// File: rtl/lsu_pkg.sv
// lsu_pkg: state encoding, widths and byte-lane helpers shared by mem_lsu_port
package lsu_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ACC0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_ACC1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_RESP  = 3'd5
  } lsu_state_e;

  function automatic logic [BYTE_W-1:0] byte_lane(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[WORD_W-1:BYTE_W] : w[BYTE_W-1:0];
  endfunction

  function automatic logic [WORD_W-1:0] ext_byte(input logic [BYTE_W-1:0] b, input logic sext);
    return {{BYTE_W{sext & b[BYTE_W-1]}}, b};
  endfunction
endpackage

// File: rtl/lsu_rd_delay.sv
// lsu_rd_delay: LAT-deep valid pipe that flags the cycle read data is valid on mem_data
module lsu_rd_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_issue,
  output logic rd_cap
);
  logic [LAT-1:0] sr_q, sr_d;
  // shift the read-issue marker one stage per cycle
  always_comb sr_d = LAT'({sr_q, rd_issue});
  // active-low synchronous clear drops any read in flight
  always_ff @(posedge clk) sr_q <= !reset ? '0 : sr_d;
  assign rd_cap = sr_q[LAT-1];
endmodule

// File: rtl/mem_lsu_port.sv
// mem_lsu_port: CPU load/store requester for the big-endian 16-bit mem port; LSU_MISALIGN_SPLIT_EN splits odd-address words
module mem_lsu_port
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter bit BYTE_SEXT  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wData,
  output logic              mem_mWrite,
  output logic              mem_mByte,
  output logic              mem_mRead,
  input  logic [WORD_W-1:0] mem_data
);
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic              wr_q, wr_d, by_q, by_d, split_q, split_d, err_q, err_d, turn_q, turn_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [BYTE_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d, resp_rd_q, resp_rd_d;
  logic              mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d, mem_by_q, mem_by_d;
  logic              resp_v_q, resp_v_d, resp_e_q, resp_e_d, ready_q, ready_d;
  logic              rd_cap, odd_word;

  lsu_rd_delay #(.LAT(MEM_RD_LAT)) u_rd_delay (
    .clk      (clk),
    .reset    (reset),
    .rd_issue (mem_rd_q),
    .rd_cap   (rd_cap)
  );

  // sequencing: accept, issue one or two mem strobes, wait for read data, respond
  always_comb begin
    odd_word    = req_addr[0] & ~req_byte;
    state_d     = state_q;
    wr_d        = wr_q;
    by_d        = by_q;
    split_d     = split_q;
    err_d       = err_q;
    turn_d      = 1'b0;
    addr1_d     = addr1_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_by_d    = 1'b0;
    resp_v_d    = 1'b0;
    resp_e_d    = 1'b0;
    resp_rd_d   = '0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d     = S_ACC0;
        wr_d        = req_write;
        by_d        = req_byte;
        split_d     = odd_word & SPLIT_EN;
        err_d       = odd_word & ~SPLIT_EN;
        addr1_d     = req_addr + ADDR_W'(1);
        lo_d        = byte_lane(req_wdata, 1'b0);
        mem_addr_d  = req_addr;
        mem_wdata_d = !req_write ? '0 : (req_byte | odd_word) ? {{BYTE_W{1'b0}}, byte_lane(req_wdata, odd_word)} : req_wdata;
        mem_wr_d    = req_write & ~err_d;
        mem_rd_d    = ~req_write & ~err_d;
        mem_by_d    = (req_byte | odd_word) & ~err_d;
      end
      S_ACC0: begin
        state_d  = (wr_q | err_q) ? (split_q ? S_ACC1 : S_RESP) : S_WAIT0;
        resp_v_d = (wr_q | err_q) & ~split_q;
        resp_e_d = err_q;
        if (wr_q & split_q) begin
          mem_addr_d  = addr1_q;
          mem_wdata_d = {{BYTE_W{1'b0}}, lo_q};
          mem_wr_d    = 1'b1;
          mem_by_d    = 1'b1;
        end
      end
      S_WAIT0: begin
        if (turn_q) begin
          state_d     = S_ACC1;
          mem_addr_d  = addr1_q;
          mem_wdata_d = '0;
          mem_rd_d    = 1'b1;
          mem_by_d    = 1'b1;
        end else if (rd_cap & split_q) begin
          hi_d   = byte_lane(mem_data, 1'b0);
          turn_d = 1'b1;
        end else if (rd_cap) begin
          state_d   = S_RESP;
          resp_v_d  = 1'b1;
          resp_rd_d = by_q ? ext_byte(byte_lane(mem_data, 1'b0), BYTE_SEXT) : mem_data;
        end
      end
      S_ACC1: begin
        state_d  = wr_q ? S_RESP : S_WAIT1;
        resp_v_d = wr_q;
      end
      S_WAIT1: if (rd_cap) begin
        state_d   = S_RESP;
        resp_v_d  = 1'b1;
        resp_rd_d = {hi_q, byte_lane(mem_data, 1'b0)};
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d = state_d == S_IDLE;
  end

  // register state, captured request and every output
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      by_q        <= 1'b0;
      split_q     <= 1'b0;
      err_q       <= 1'b0;
      turn_q      <= 1'b0;
      addr1_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_by_q    <= 1'b0;
      resp_v_q    <= 1'b0;
      resp_e_q    <= 1'b0;
      resp_rd_q   <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      by_q        <= by_d;
      split_q     <= split_d;
      err_q       <= err_d;
      turn_q      <= turn_d;
      addr1_q     <= addr1_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_by_q    <= mem_by_d;
      resp_v_q    <= resp_v_d;
      resp_e_q    <= resp_e_d;
      resp_rd_q   <= resp_rd_d;
      ready_q     <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_v_q;
  assign resp_err   = resp_e_q;
  assign resp_rdata = resp_rd_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wData  = mem_wdata_q;
  assign mem_mWrite = mem_wr_q;
  assign mem_mRead  = mem_rd_q;
  assign mem_mByte  = mem_by_q;
endmodule

// File: tb/tb_mem_lsu_port.sv
// tb_mem_lsu_port: randomized scoreboard bench for mem_lsu_port against a byte-level big-endian memory model
module tb_mem_lsu_port;
  localparam int L    = 2;
  localparam bit SEXT = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_mWrite, mem_mByte, mem_mRead;
  logic [15:0] resp_rdata, mem_addr, mem_wData, mem_data;
  int          cyc = 0, n_cmp = 0, n_bad = 0;
  bit          live = 1'b0;

  typedef struct {logic [15:0] rdata; bit err; int lat; int t0;} resp_t;
  typedef struct {bit wr; bit by; logic [15:0] a; logic [15:0] d;} strb_t;
  resp_t       rq[$];
  strb_t       sq[$];
  logic [7:0]  bus_mem [int];
  logic [7:0]  ref_mem [int];
  logic [15:0] rd_pipe [L];

  mem_lsu_port #(.MEM_RD_LAT(L), .BYTE_SEXT(SEXT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wData(mem_wData), .mem_mWrite(mem_mWrite),
    .mem_mByte(mem_mByte), .mem_mRead(mem_mRead), .mem_data(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return 8'((int'(a) * 37) ^ 'h5C);
  endfunction

  function automatic logic [7:0] ref_get(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction

  function automatic logic [7:0] bus_get(input logic [15:0] a);
    return bus_mem.exists(int'(a)) ? bus_mem[int'(a)] : init_byte(a);
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endfunction

  // mem responder: writes land at the strobe edge, reads appear L cycles after the mRead cycle
  assign mem_data = rd_pipe[L-1];
  always @(posedge clk) begin
    logic [15:0] a1;
    a1 = mem_addr + 16'd1;
    if (mem_mWrite === 1'b1) begin
      if (mem_mByte) bus_mem[int'(mem_addr)] = mem_wData[7:0];
      else begin
        bus_mem[int'(mem_addr)] = mem_wData[15:8];
        bus_mem[int'(a1)] = mem_wData[7:0];
      end
    end
    for (int i = L - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_mRead !== 1'b1) ? 16'hDEAD : mem_mByte ? {8'hEE, bus_get(mem_addr)} : {bus_get(mem_addr), bus_get(a1)};
  end

  // monitor: pops expected strobes and responses whenever the DUT presents them
  always @(negedge clk) if (live) begin
    if (mem_mRead === 1'b1 || mem_mWrite === 1'b1) begin
      chk("rd_wr_exclusive", 32'(mem_mRead & mem_mWrite), 32'(0));
      if (sq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_strobe: got rd=%b wr=%b addr=%h required none", mem_mRead, mem_mWrite, mem_addr);
      end else begin
        strb_t e;
        e = sq.pop_front();
        chk("strobe_write", 32'(mem_mWrite), 32'(e.wr));
        chk("strobe_byte", 32'(mem_mByte), 32'(e.by));
        chk("strobe_addr", 32'(mem_addr), 32'(e.a));
        if (e.wr) chk("strobe_wdata", 32'(mem_wData), 32'(e.d));
      end
    end
    if (resp_valid === 1'b1) begin
      if (rq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b required no response", resp_rdata, resp_err);
      end else begin
        resp_t r;
        r = rq.pop_front();
        chk("resp_rdata", 32'(resp_rdata), 32'(r.rdata));
        chk("resp_err", 32'(resp_err), 32'(r.err));
        chk("resp_latency", 32'(cyc - r.t0), 32'(r.lat));
      end
    end
  end

  // reference: big-endian byte memory; expectations computed when the request is accepted
  task automatic expect_req(input bit w, input bit b, input logic [15:0] a, input logic [15:0] d);
    resp_t r;
    logic [15:0] a1;
    logic [7:0] v;
    bit odd;
    a1 = a + 16'd1;
    odd = a[0] & ~b;
    r.t0 = cyc; r.err = 1'b0; r.rdata = '0; r.lat = 0;
    if (odd && !SPLIT) begin
      r.err = 1'b1;
      r.lat = 2;
    end else if (b) begin
      r.lat = w ? 2 : L + 2;
      sq.push_back('{w, 1'b1, a, {8'h00, d[7:0]}});
      v = ref_get(a);
      if (w) ref_mem[int'(a)] = d[7:0];
      else r.rdata = SEXT ? 16'($signed(v)) : {8'h00, v};
    end else begin
      if (odd) begin
        r.lat = w ? 3 : 2 * L + 4;
        sq.push_back('{w, 1'b1, a, {8'h00, d[15:8]}});
        sq.push_back('{w, 1'b1, a1, {8'h00, d[7:0]}});
      end else begin
        r.lat = w ? 2 : L + 2;
        sq.push_back('{w, 1'b0, a, d});
      end
      if (w) begin
        ref_mem[int'(a)] = d[15:8];
        ref_mem[int'(a1)] = d[7:0];
      end else r.rdata = {ref_get(a), ref_get(a1)};
    end
    rq.push_back(r);
  endtask

  // present a request from a negedge; returns at the negedge after it is accepted
  task automatic issue(input bit w, input bit b, input logic [15:0] a, input logic [15:0] d, input bit keep);
    int t;
    t = 0;
    req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = d;
    while (req_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=%b for 100 cycles required 1", req_ready);
    end else expect_req(w, b, a, d);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'(1));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_resp_err", 32'(resp_err), 32'(0));
    chk("rst_resp_rdata", 32'(resp_rdata), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wData), 32'(0));
    chk("rst_strobes", 32'({mem_mWrite, mem_mRead, mem_mByte}), 32'(0));
    reset = 1'b1;
    live = 1'b1;
    @(negedge clk);
    issue(1, 0, 16'h0004, 16'hBBBB, 0); repeat (4) @(negedge clk);
    issue(0, 0, 16'h0004, 16'h0000, 0); repeat (6) @(negedge clk);
    issue(1, 1, 16'h0007, 16'h005A, 0); repeat (4) @(negedge clk);
    issue(0, 1, 16'h0007, 16'h0000, 0); repeat (6) @(negedge clk);
    issue(1, 1, 16'h0008, 16'h00A5, 0); repeat (4) @(negedge clk);
    issue(0, 1, 16'h0008, 16'h0000, 0); repeat (6) @(negedge clk);
    issue(1, 0, 16'h0003, 16'h1234, 0); repeat (4) @(negedge clk);
    issue(0, 0, 16'h0003, 16'h0000, 0); repeat (10) @(negedge clk);
    issue(1, 0, 16'hFFFF, 16'hCAFE, 0); repeat (4) @(negedge clk);
    issue(0, 0, 16'hFFFF, 16'h0000, 0); repeat (10) @(negedge clk);
    issue(1, 0, 16'h0010, 16'h1111, 1);
    issue(0, 1, 16'h0010, 16'h0000, 1);
    issue(0, 0, 16'h0010, 16'h0000, 0); repeat (10) @(negedge clk);
    chk("b2b_drained", 32'(rq.size()), 32'(0));
    issue(0, 0, 16'h0004, 16'h0000, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rq.delete();
    sq.delete();
    chk("abort_ready", 32'(req_ready), 32'(1));
    chk("abort_strobes", 32'({mem_mWrite, mem_mRead, mem_mByte}), 32'(0));
    chk("abort_resp_valid", 32'(resp_valid), 32'(0));
    repeat (L + 6) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      bit w, b, keep;
      logic [15:0] a, d;
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom_range(0, 15));
      d = 16'($urandom);
      keep = ($urandom_range(0, 2) == 0);
      issue(w, b, a, d, keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    req_valid = 1'b0;
    for (int t = 0; t < 200 && rq.size() > 0; t++) @(negedge clk);
    chk("drain_resp", 32'(rq.size()), 32'(0));
    chk("drain_strobe", 32'(sq.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
